// File: rtl/fp32_mul_scheduler.sv
// Round-robin arbiter sharing one FP32 multiplier among NREQ requesters; response MUL_LAT+1 falling edges after grant.
// Backpressure only through the one-hot combinational grant; responses cannot be stalled.
module fp32_mul_scheduler #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 7,
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNT_W  = $clog2(MUL_LAT + 2)
) (
  input  logic                 clkn_i,
  input  logic                 rstn_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [31:0]          mul_a_o,
  output logic [31:0]          mul_b_o,
  input  logic [31:0]          mul_result_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [31:0]          rsp_result_o,
  output logic [CNT_W-1:0]     inflight_o,
  output logic [15:0]          issue_cnt_o
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             found;
  logic             retire;

  logic [MUL_LAT-1:0] pipe_vld;
  logic [PTR_W-1:0]   pipe_idx [MUL_LAT];

  // Search starts at ptr and wraps; the grant is suppressed during reset.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req_valid_i[(int'(ptr) + off) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'((int'(ptr) + off) % NREQ);
      end
    end
    gnt_vld = found & rstn_i;
  end

  assign req_ready_o = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  assign mul_a_o     = gnt_vld ? req_a_i[32*int'(gnt_idx) +: 32] : '0;
  assign mul_b_o     = gnt_vld ? req_b_i[32*int'(gnt_idx) +: 32] : '0;
  assign ptr_nxt     = (int'(gnt_idx) == NREQ - 1) ? '0 : PTR_W'(gnt_idx + 1'b1);
  assign retire      = |rsp_valid_o;

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= ptr_nxt;
    end
  end

  // Tag pipeline tracks the multiplier; its tail lines up with mul_result_i.
  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pipe_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) pipe_idx[s] <= '0;
    end else begin
      pipe_vld[0] <= gnt_vld;
      pipe_idx[0] <= gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid_o  <= '0;
      rsp_result_o <= '0;
    end else if (pipe_vld[MUL_LAT-1]) begin
      rsp_valid_o  <= NREQ'(1) << pipe_idx[MUL_LAT-1];
      rsp_result_o <= mul_result_i;
    end else begin
      rsp_valid_o  <= '0;
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_o  <= '0;
      issue_cnt_o <= '0;
    end else begin
      case ({gnt_vld, retire})
        2'b10:   inflight_o <= CNT_W'(inflight_o + 1'b1);
        2'b01:   inflight_o <= CNT_W'(inflight_o - 1'b1);
        default: inflight_o <= inflight_o;
      endcase
      if (gnt_vld) issue_cnt_o <= issue_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp32_mul_scheduler.sv
// Scoreboard bench: round-robin reference and FP32 multiplier model, with a decoupled response monitor.
module tb_fp32_mul_scheduler;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 7;
  localparam int CNT_W   = $clog2(MUL_LAT + 2);

  logic                clkn_i;
  logic                rstn_i;
  logic [NREQ-1:0]     req_valid_i;
  logic [32*NREQ-1:0]  req_a_i;
  logic [32*NREQ-1:0]  req_b_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [31:0]         mul_a_o;
  logic [31:0]         mul_b_o;
  logic [31:0]         mul_result_i;
  logic [NREQ-1:0]     rsp_valid_o;
  logic [31:0]         rsp_result_o;
  logic [CNT_W-1:0]    inflight_o;
  logic [15:0]         issue_cnt_o;

  fp32_mul_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clkn_i(clkn_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_ready_o(req_ready_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_result_i(mul_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o),
    .inflight_o(inflight_o), .issue_cnt_o(issue_cnt_o)
  );

  initial begin
    clkn_i = 1'b1;
    forever #5 clkn_i = ~clkn_i;
  end

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // IEEE-754 single multiply for normal operands and results, via an exact double product.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dp;
    logic [28:0] lo;
    logic [31:0] r;
    da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    dp = $realtobits($bitstoreal(da) * $bitstoreal(db));
    r  = {dp[63], 8'(dp[62:52] - 11'd896), dp[51:29]};
    lo = dp[28:0];
    if (lo > 29'h1000_0000 || (lo == 29'h1000_0000 && r[0])) r = r + 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom())};
  endfunction

  logic [31:0] a_op [NREQ];
  logic [31:0] b_op [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign req_a_i[32*gi +: 32] = a_op[gi];
    assign req_b_i[32*gi +: 32] = b_op[gi];
  end

  // External multiplier: MUL_LAT falling edges from capture to result.
  logic [31:0] mpipe [MUL_LAT];
  assign mul_result_i = mpipe[MUL_LAT-1];
  always @(negedge clkn_i) begin
    mpipe[0] <= fmul(mul_a_o, mul_b_o);
    for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
  end

  int cyc = 0;
  always @(negedge clkn_i) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t            sbq[$];
  int              ref_ptr = 0;
  logic [15:0]     model_cnt = '0;
  logic [31:0]     last_res = '0;
  logic [NREQ-1:0] hs_prev = '0;

  // Reference arbiter: decides the grant from the presented valids and pushes expectations.
  always @(posedge clkn_i) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    if (rstn_i) begin
      g = -1;
      for (int off = 0; off < NREQ; off++)
        if (g < 0 && req_valid_i[(ref_ptr + off) % NREQ]) g = (ref_ptr + off) % NREQ;
      exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
      chk("inflight", 32'(inflight_o), 32'(sbq.size()));
      chk("issue_cnt", 32'(issue_cnt_o), 32'(model_cnt));
      chk("grant", 32'(req_ready_o), 32'(exp_rdy));
      chk("mul_a", mul_a_o, (g >= 0) ? a_op[g] : 32'd0);
      chk("mul_b", mul_b_o, (g >= 0) ? b_op[g] : 32'd0);
      if (g >= 0) begin
        sbq.push_back('{g, fmul(a_op[g], b_op[g]), cyc + MUL_LAT + 1});
        ref_ptr   = (g + 1) % NREQ;
        model_cnt = model_cnt + 16'd1;
      end
      hs_prev = exp_rdy;
    end
  end

  always @(posedge clkn_i) begin
    exp_t e;
    #2;
    if (rstn_i) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("rsp_missing_due", 32'(cyc), 32'(sbq[0].due));
        void'(sbq.pop_front());
      end
      if (rsp_valid_o != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", 32'(rsp_valid_o), 32'(NREQ'(1) << e.idx));
          chk("rsp_result", rsp_result_o, e.res);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          last_res = e.res;
        end
      end else begin
        chk("rsp_hold", rsp_result_o, last_res);
      end
    end
  end

  task automatic next_cyc();
    @(negedge clkn_i);
    #1;
  endtask

  task automatic new_op(input int i);
    a_op[i] = rnd_fp();
    b_op[i] = rnd_fp();
  endtask

  task automatic do_reset();
    next_cyc();
    req_valid_i = '1;
    rstn_i      = 1'b0;
    sbq.delete();
    ref_ptr   = 0;
    model_cnt = '0;
    last_res  = '0;
    hs_prev   = '0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_result", rsp_result_o, 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt_o), 32'd0);
    req_valid_i = '0;
    #2 rstn_i = 1'b1;
  endtask

  // Requesters hold valid/operands until handshake, then re-request with probability pct.
  task automatic run(input int n, input int pct);
    repeat (n) begin
      next_cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid_i[i] || hs_prev[i]) begin
          req_valid_i[i] = ($urandom_range(99, 0) < pct);
          if (req_valid_i[i]) new_op(i);
        end
      end
    end
  endtask

  initial begin
    int c0, seen;
    bit got;
    int seq [5];
    logic [15:0] cnt0;
    rstn_i      = 1'b0;
    req_valid_i = '0;
    for (int i = 0; i < NREQ; i++) begin a_op[i] = '0; b_op[i] = '0; end
    do_reset();

    // Single request from requester 2.
    next_cyc();
    req_valid_i = 4'b0100;
    a_op[2] = 32'h4000_0000;
    b_op[2] = 32'h4040_0000;
    @(posedge clkn_i); #1;
    chk("single_ready", 32'(req_ready_o), 32'h4);
    c0 = cyc;
    next_cyc();
    req_valid_i = '0;
    chk("single_inflight_1", 32'(inflight_o), 32'd1);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clkn_i); #1;
      if (rsp_valid_o != '0) begin
        got = 1'b1;
        chk("single_rsp_valid", 32'(rsp_valid_o), 32'h4);
        chk("single_rsp_result", rsp_result_o, 32'h40C0_0000);
        chk("single_rsp_cycle", 32'(cyc - c0), 32'(MUL_LAT + 1));
      end
    end
    if (!got) chk("single_rsp_timeout", 32'(cyc - c0), 32'(MUL_LAT + 1));
    next_cyc();
    chk("single_inflight_0", 32'(inflight_o), 32'd0);

    // Full contention from ptr=0.
    do_reset();
    seq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      if (k == 0) begin
        req_valid_i = '1;
        for (int i = 0; i < NREQ; i++) new_op(i);
      end else begin
        new_op(seq[k-1]);
      end
      @(posedge clkn_i); #1;
      chk("rr_seq", 32'(req_ready_o), 32'(NREQ'(1) << seq[k]));
    end
    next_cyc();
    req_valid_i = '0;
    repeat (12) next_cyc();

    // Pointer wrap: ptr currently 1; grant 1 and 2 to bring it to 3.
    req_valid_i = 4'b0110; new_op(1); new_op(2);
    next_cyc(); next_cyc();
    req_valid_i = 4'b1001; new_op(0); new_op(3);
    @(posedge clkn_i); #1;
    chk("wrap_grant3", 32'(req_ready_o), 32'h8);
    next_cyc();
    req_valid_i = 4'b0001;
    @(posedge clkn_i); #1;
    chk("wrap_grant0", 32'(req_ready_o), 32'h1);
    next_cyc();
    req_valid_i = 4'b1111; new_op(0);
    @(posedge clkn_i); #1;
    chk("wrap_ptr_end", 32'(req_ready_o), 32'h2);
    next_cyc();
    req_valid_i = '0;
    repeat (12) next_cyc();

    // Idle window.
    cnt0 = issue_cnt_o;
    for (int n = 0; n < 10; n++) begin
      @(posedge clkn_i); #1;
      chk("idle_mul_a", mul_a_o, 32'd0);
      chk("idle_mul_b", mul_b_o, 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("idle_issue_cnt", 32'(issue_cnt_o), 32'(cnt0));
    end

    run(400, 60);
    next_cyc();
    req_valid_i = '0;
    repeat (12) next_cyc();

    // Reset with three requests in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      req_valid_i = NREQ'(1) << k;
      new_op(k);
    end
    next_cyc();
    req_valid_i = '0;
    do_reset();
    seen = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clkn_i); #1;
      if (rsp_valid_o != '0) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);

    // Issue counter wrap.
    do_reset();
    forever begin
      next_cyc();
      if (model_cnt == 16'hFFFF) break;
      req_valid_i = 4'b0001;
      new_op(0);
    end
    req_valid_i = '0;
    chk("cnt_at_ffff", 32'(issue_cnt_o), 32'h0000_FFFF);
    req_valid_i = 4'b0001;
    new_op(0);
    next_cyc();
    req_valid_i = '0;
    chk("cnt_wrapped", 32'(issue_cnt_o), 32'd0);
    repeat (12) next_cyc();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fp32_mul_scheduler.md
FP32_MUL_SCHEDULER -- requirements
Module: fp32_mul_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one FP32 multiplier.
REQ-002 SHALL have parameter MUL_LAT, default 7: multiplier latency in clkn_i falling edges, from operand capture to result valid.
REQ-003 SHALL have port clkn_i, input, 1: single clock; all state updates on its falling edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i, input, NREQ: per-requester operand-pair valid.
REQ-006 SHALL have port req_a_i, input, 32*NREQ: operand A of requester i, bits [32i+31:32i].
REQ-007 SHALL have port req_b_i, input, 32*NREQ: operand B of requester i, bits [32i+31:32i].
REQ-008 SHALL have port req_ready_o, input-to-output combinational, NREQ: one-hot grant; handshake when req_valid_i[i] & req_ready_o[i].
REQ-009 SHALL have port mul_a_o, output, 32: operand A to shared multiplier.
REQ-010 SHALL have port mul_b_o, output, 32: operand B to shared multiplier.
REQ-011 SHALL have port mul_result_i, input, 32: multiplier result.
REQ-012 SHALL have port rsp_valid_o, output, NREQ: registered one-hot response valid, one cycle per accepted request.
REQ-013 SHALL have port rsp_result_o, output, 32: registered result, meaningful only while any rsp_valid_o bit is set.
REQ-014 SHALL have port inflight_o, output, clog2(MUL_LAT+2): number of issued requests not yet responded.
REQ-015 SHALL have port issue_cnt_o, output, 16: total accepted requests, wraps 0xFFFF->0x0000.

Function
REQ-016 SHALL keep a round-robin pointer ptr in range 0..NREQ-1; the granted requester is the first i with req_valid_i[i]=1, searched ptr, ptr+1, ... modulo NREQ.
REQ-017 SHALL assert at most one req_ready_o bit per cycle; all bits are 0 when no req_valid_i bit is set.
REQ-018 SHALL, on a grant to i, set ptr to (i+1) mod NREQ at the falling edge; ptr SHALL be unchanged when there is no grant.
REQ-019 SHALL accept at most one request per cycle, with no bubbles required between back-to-back grants.
REQ-020 SHALL drive mul_a_o/mul_b_o combinationally with the granted requester's operands in the grant cycle, and with 0x00000000 when there is no grant.
REQ-021 SHALL carry a valid bit and a requester index through a MUL_LAT-stage shift register advanced every falling edge; stage 0 loads the grant and stage MUL_LAT-1 aligns with mul_result_i.
REQ-022 SHALL, for a handshake in cycle k, assert rsp_valid_o[i] for exactly cycle k+MUL_LAT+1, with rsp_result_o = mul_result_i as sampled at the end of cycle k+MUL_LAT.
REQ-023 SHALL return responses in issue order; a requester with several requests in flight receives them in that order.
REQ-024 SHALL hold rsp_result_o at its last value when no response is valid; rsp_valid_o SHALL then be 0.
REQ-025 SHALL, on a simultaneous issue and retire in one cycle, leave inflight_o unchanged; otherwise inflight_o SHALL increment on issue and decrement on retire, never exceeding MUL_LAT+1.
REQ-026 SHALL apply no backpressure on responses; requesters must accept rsp_valid_o when it is asserted.
REQ-027 SHALL leave requesters responsible for holding req_valid_i and operands stable until the handshake; the scheduler does not check this.

Reset
REQ-028 SHALL, while rstn_i=0, clear ptr, all shift-register valid bits, rsp_valid_o, rsp_result_o, inflight_o and issue_cnt_o to 0, asynchronously.
REQ-029 SHALL, on reset mid-operation, discard in-flight requests: no rsp_valid_o for them after release, and mul_result_i is ignored until new grants reach the tail.
REQ-030 SHALL keep req_ready_o at 0 while rstn_i=0.

Verification
REQ-031 Single request: requester 2 presents A=0x40000000, B=0x40400000 in cycle 0 -> ready[2]=1 in cycle 0; rsp_valid_o=0b0100 in cycle 8 (MUL_LAT=7) with result 0x40C00000; inflight_o goes 0->1->0.
REQ-032 Contention: all 4 valid continuously from ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; responses arrive in the same order on cycles 8..12.
REQ-033 Wrap: ptr=3, requesters 0 and 3 valid -> grant 3 then grant 0; ptr ends at 1.
REQ-034 Idle: no valid for 10 cycles -> mul_a_o=mul_b_o=0, rsp_valid_o=0, issue_cnt_o unchanged.
REQ-035 Reset mid-flight: 3 grants issued, rstn_i pulsed low in cycle 4 -> outputs are 0 immediately; no rsp_valid_o in cycles 5..20 without new requests.
REQ-036 Counter wrap: issue_cnt_o preloaded to 0xFFFF by 65535 grants, then one more grant -> issue_cnt_o=0x0000.
